// File: rtl/my_isa_pkg.sv
// -----------------------------------------------------------------------------
// my_isa_pkg
//   Shared definitions for the 16-bit ALU core ISA and its control sequencer.
//   Instruction format: ir[15:12] major, ir[11:8] rd, ir[7:4] func, ir[3:0] rs/imm.
//   Contents:
//     MAJ_*        major opcode values (ALU, HALT)
//     F_*          ALU func codes
//     state_t      sequencer state encoding (3-bit)
//     alu_sel_t    one-hot ALU operation selects handed to the datapath
//     is_legal_func() true for any defined ALU func code
// -----------------------------------------------------------------------------
package my_isa_pkg;

  localparam logic [3:0] MAJ_ALU  = 4'b0000;
  localparam logic [3:0] MAJ_HALT = 4'b1111;

  localparam logic [3:0] F_ADD  = 4'b1010;
  localparam logic [3:0] F_ADDI = 4'b1001;
  localparam logic [3:0] F_SUB  = 4'b1100;
  localparam logic [3:0] F_AND  = 4'b1110;
  localparam logic [3:0] F_OR   = 4'b0010;
  localparam logic [3:0] F_XOR  = 4'b0110;
  localparam logic [3:0] F_NOT  = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ADDI shares the adder with ADD; the B-operand mux is steered by use_imm.
  typedef struct packed {
    logic s_add;
    logic s_sub;
    logic s_and;
    logic s_or;
    logic s_xor;
    logic s_not;
  } alu_sel_t;

  function automatic logic is_legal_func(input logic [3:0] func);
    case (func)
      F_ADD, F_ADDI, F_SUB, F_AND, F_OR, F_XOR, F_NOT: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/my_decoder.sv
// -----------------------------------------------------------------------------
// my_decoder
//   Pure combinational classification of the instruction register fields.
//   Ports:
//     major   in  4  ir[15:12]
//     func    in  4  ir[7:4]
//     alu_sel out    one-hot ALU operation selects (all zero unless legal ALU op)
//     use_imm out 1  ADDI: ALU B operand is zero-extended ir[3:0]
//     is_alu  out 1  major is ALU and func is a defined operation
//     is_halt out 1  major is HALT
// -----------------------------------------------------------------------------
module my_decoder
  import my_isa_pkg::*;
(
  input  logic [3:0] major,
  input  logic [3:0] func,
  output alu_sel_t   alu_sel,
  output logic       use_imm,
  output logic       is_alu,
  output logic       is_halt
);

  assign is_alu  = (major == MAJ_ALU) && is_legal_func(func);
  assign is_halt = (major == MAJ_HALT);
  assign use_imm = (major == MAJ_ALU) && (func == F_ADDI);

  always_comb begin
    alu_sel = '0;
    if (major == MAJ_ALU) begin
      case (func)
        F_ADD, F_ADDI: alu_sel.s_add = 1'b1;
        F_SUB:         alu_sel.s_sub = 1'b1;
        F_AND:         alu_sel.s_and = 1'b1;
        F_OR:          alu_sel.s_or  = 1'b1;
        F_XOR:         alu_sel.s_xor = 1'b1;
        F_NOT:         alu_sel.s_not = 1'b1;
        default:       alu_sel       = '0;
      endcase
    end
  end

endmodule

// File: rtl/my_sequencer.sv
// -----------------------------------------------------------------------------
// my_sequencer
//   Multi-cycle control FSM for the 16-bit ALU core: fetches an instruction,
//   holds it in the IR, then sequences register read (DECODE), ALU execute
//   (EXEC) and register write-back (WB).
//
//   Optional feature: define MY_SEQ_ILLEGAL_TRAP_EN to halt with a sticky err
//   on an illegal instruction. Without it, illegal instructions act as NOPs
//   and err is tied low.
//
//   Fetch handshake: mem_req is the request (valid) and mem_ack the completion
//   (ready). mem_req rises on entry to FETCH and is held, with mem_addr stable,
//   until the first cycle mem_ack is seen high; mem_rdata is captured on that
//   edge. mem_ack while mem_req is low is ignored.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        begin execution at RST_PC (honoured in IDLE/HALT only)
//     mem_req/mem_addr/mem_rdata/mem_ack   instruction fetch interface
//     ir           instruction register
//     rf_raddr_a/rf_raddr_b/rf_waddr       register-file addresses from ir
//     use_imm      ADDI immediate select
//     alu_sel      one-hot ALU operation selects
//     alu_en       one-cycle ALU latch enable (EXEC)
//     rf_we        one-cycle register-file write enable (WB)
//     busy/halted/err   status
//     state        current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module my_sequencer
  import my_isa_pkg::*;
#(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_ack,
  output logic [15:0]     ir,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  output logic            use_imm,
  output alu_sel_t        alu_sel,
  output logic            alu_en,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output state_t          state
);

  logic [PC_W-1:0] pc;
  logic            dec_alu;
  logic            dec_halt;
  logic            start_ok;

  my_decoder u_decoder (
    .major   (ir[15:12]),
    .func    (ir[7:4]),
    .alu_sel (alu_sel),
    .use_imm (use_imm),
    .is_alu  (dec_alu),
    .is_halt (dec_halt)
  );

  assign mem_addr   = pc;
  assign rf_raddr_a = ir[11:8];
  assign rf_raddr_b = ir[3:0];
  assign rf_waddr   = ir[11:8];
  assign start_ok   = start && ((state == S_IDLE) || (state == S_HALT));

  // All control outputs are registered and set on the edge that enters the
  // state which owns them, so alu_en/rf_we are clean single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RST_PC;
      ir      <= '0;
      mem_req <= 1'b0;
      alu_en  <= 1'b0;
      rf_we   <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= RST_PC;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + PC_W'(1);  // wraps silently at 2^PC_W
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec_alu) begin
            state  <= S_EXEC;
            alu_en <= 1'b1;
          end else if (dec_halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
`ifdef MY_SEQ_ILLEGAL_TRAP_EN
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
`else
            // Illegal instruction skipped: straight back to fetch.
            state   <= S_FETCH;
            mem_req <= 1'b1;
`endif
          end
        end
        S_EXEC: begin
          state <= S_WB;
          rf_we <= 1'b1;
        end
        S_WB: begin
          state   <= S_FETCH;
          mem_req <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MY_SEQ_ILLEGAL_TRAP_EN
  logic err_q;

  // Sticky until the next accepted start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if ((state == S_DECODE) && !dec_alu && !dec_halt) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign err             = 1'b0;
`endif

endmodule

// File: tb/tb_my_sequencer.sv
// -----------------------------------------------------------------------------
// tb_my_sequencer
//   Directed plus randomized checks of my_sequencer. Inputs are driven and
//   outputs sampled on the falling clock edge. A second instance with
//   RST_PC = 8'hFF covers program-counter wrap.
//   Honours MY_SEQ_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
// -----------------------------------------------------------------------------
module tb_my_sequencer;
  import my_isa_pkg::*;

`ifdef MY_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [3:0] LEGAL_F [7] = '{4'hA, 4'h9, 4'hC, 4'hE, 4'h2, 4'h6, 4'hB};
  localparam logic [3:0] ILL_F   [9] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hD, 4'hF};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RST_PC = 0) ----------------
  logic        start     = 1'b0;
  logic        mem_ack   = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_req, use_imm, alu_en, rf_we, busy, halted, err;
  logic [7:0]  mem_addr;
  logic [15:0] ir;
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  alu_sel_t    alu_sel;
  state_t      state;

  my_sequencer #(.PC_W(8), .RST_PC(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ir(ir), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .use_imm(use_imm),
    .alu_sel(alu_sel), .alu_en(alu_en), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .busy(busy), .halted(halted), .err(err), .state(state)
  );

  // ---------------- wrap DUT (RST_PC = FF) ----------------
  logic        w_start = 1'b0;
  logic        w_ack   = 1'b0;
  logic [15:0] w_rdata = '0;
  logic        w_req, w_use_imm, w_alu_en, w_rf_we, w_busy, w_halted, w_err;
  logic [7:0]  w_addr;
  logic [15:0] w_ir;
  logic [3:0]  w_raddr_a, w_raddr_b, w_waddr;
  alu_sel_t    w_alu_sel;
  state_t      w_state;

  my_sequencer #(.PC_W(8), .RST_PC(8'hFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start),
    .mem_req(w_req), .mem_addr(w_addr), .mem_rdata(w_rdata), .mem_ack(w_ack),
    .ir(w_ir), .rf_raddr_a(w_raddr_a), .rf_raddr_b(w_raddr_b), .use_imm(w_use_imm),
    .alu_sel(w_alu_sel), .alu_en(w_alu_en), .rf_we(w_rf_we), .rf_waddr(w_waddr),
    .busy(w_busy), .halted(w_halted), .err(w_err), .state(w_state)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];  // instruction words whose write-back is still due

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Every rf_we pulse must match the oldest outstanding legal ALU instruction.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_spurious", 32'(rf_we), 32'd0);
      end else begin
        logic [15:0] w;
        w = exp_q.pop_front();
        chk("wb_waddr", 32'(rf_waddr), 32'(w[11:8]));
        chk("wb_ir", 32'(ir), 32'(w));
      end
    end
  end

  // ---------------- reference model ----------------
  // 0 = legal ALU op, 1 = HALT, 2 = illegal
  function automatic int classify(input logic [15:0] w);
    if (w[15:12] == 4'hF) return 1;
    if (w[15:12] == 4'h0) begin
      for (int i = 0; i < 7; i++) if (w[7:4] == LEGAL_F[i]) return 0;
    end
    return 2;
  endfunction

  function automatic logic exp_imm(input logic [15:0] w);
    return (w[15:12] == 4'h0) && (w[7:4] == 4'h9);
  endfunction

  // {add, sub, and, or, xor, not}
  function automatic logic [5:0] exp_sel(input logic [15:0] w);
    if (w[15:12] != 4'h0) return 6'b0;
    case (w[7:4])
      4'hA, 4'h9: return 6'b100000;
      4'hC:       return 6'b010000;
      4'hE:       return 6'b001000;
      4'h2:       return 6'b000100;
      4'h6:       return 6'b000010;
      4'hB:       return 6'b000001;
      default:    return 6'b000000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag, input logic [7:0] pc0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_alu_en"},  32'(alu_en),  32'd0);
    chk({tag, "_rf_we"},   32'(rf_we),   32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_halted"},  32'(halted),  32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
    chk({tag, "_ir"},      32'(ir),      32'd0);
    chk({tag, "_addr"},    32'(mem_addr), 32'(pc0));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy",   32'(busy),    32'd1);
    chk("start_halted", 32'(halted),  32'd0);
    chk("start_err",    32'(err),     32'd0);
    chk("start_req",    32'(mem_req), 32'd1);
  endtask

  // Entered at a falling edge with the DUT in FETCH. Serves one fetch after
  // `delay` wait cycles, then checks the cycle-by-cycle consequence.
  task automatic run_instr(input logic [15:0] word, input int delay,
                           input logic [7:0] exp_pc, output bit stop);
    int kind;
    kind = classify(word);
    stop = 1'b0;
    chk("fetch_req",  32'(mem_req),  32'd1);
    chk("fetch_addr", 32'(mem_addr), 32'(exp_pc));
    chk("fetch_busy", 32'(busy),     32'd1);
    for (int i = 0; i < delay; i++) begin
      start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));  // ignored while busy
      tick();
      chk("req_held",    32'(mem_req),  32'd1);
      chk("addr_stable", 32'(mem_addr), 32'(exp_pc));
    end
    start     = 1'($urandom_range(0, 1));  // ack wins over a coincident start
    mem_ack   = 1'b1;
    mem_rdata = word;
    tick();
    // DECODE: ack and start from here on must be ignored
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = 16'($urandom);
    start     = 1'($urandom_range(0, 1));
    chk("dec_ir",     32'(ir),         32'(word));
    chk("dec_req",    32'(mem_req),    32'd0);
    chk("dec_busy",   32'(busy),       32'd1);
    chk("dec_alu_en", 32'(alu_en),     32'd0);
    chk("dec_rf_we",  32'(rf_we),      32'd0);
    chk("dec_imm",    32'(use_imm),    32'(exp_imm(word)));
    chk("dec_raddr_a", 32'(rf_raddr_a), 32'(word[11:8]));
    if (kind == 0) begin
      exp_q.push_back(word);
      tick();
      chk("exec_alu_en",  32'(alu_en),     32'd1);
      chk("exec_rf_we",   32'(rf_we),      32'd0);
      chk("exec_imm",     32'(use_imm),    32'(exp_imm(word)));
      chk("exec_sel",     32'(alu_sel),    32'(exp_sel(word)));
      chk("exec_raddr_b", 32'(rf_raddr_b), 32'(word[3:0]));
      tick();
      chk("wb_rf_we",  32'(rf_we),   32'd1);
      chk("wb_alu_en", 32'(alu_en),  32'd0);
      chk("wb_req",    32'(mem_req), 32'd0);
      tick();
      mem_ack = 1'b0;
      start   = 1'b0;
      chk("next_req",   32'(mem_req), 32'd1);
      chk("next_rf_we", 32'(rf_we),   32'd0);
    end else if (kind == 1 || TRAP) begin
      tick();
      mem_ack = 1'b0;
      start   = 1'b0;
      chk("halt_halted", 32'(halted),  32'd1);
      chk("halt_busy",   32'(busy),    32'd0);
      chk("halt_req",    32'(mem_req), 32'd0);
      chk("halt_rf_we",  32'(rf_we),   32'd0);
      chk("halt_err",    32'(err),     32'(kind == 2));
      stop = 1'b1;
    end else begin
      tick();
      mem_ack = 1'b0;
      start   = 1'b0;
      chk("nop_req",    32'(mem_req), 32'd1);
      chk("nop_rf_we",  32'(rf_we),   32'd0);
      chk("nop_alu_en", 32'(alu_en),  32'd0);
      chk("nop_err",    32'(err),     32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit          stop;
    logic [7:0]  pc;
    logic [15:0] word;
    int          r;

    // reset and idle behaviour
    tick();
    chk_reset("rst", 8'h00);
    chk("rst_wrap_addr", 32'(w_addr), 32'h0FF);
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset("idle", 8'h00);
    mem_ack   = 1'b1;  // no request outstanding: must be ignored
    mem_rdata = 16'h03A2;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ir",  32'(ir),      32'd0);
    chk("idle_ack_req", 32'(mem_req), 32'd0);

    // ADD r3,r2 with ack on the second request cycle
    do_start();
    run_instr(16'h03A2, 1, 8'h00, stop);
    // ADDI r5,#7
    run_instr(16'h0597, 0, 8'h01, stop);
    // ADD, SUB, HALT
    run_instr(16'h04A5, 2, 8'h02, stop);
    run_instr(16'h06C1, 0, 8'h03, stop);
    run_instr(16'hF000, 1, 8'h04, stop);
    chk("prog_stop", 32'(stop), 32'd1);
    tick();
    chk("halt_stays",   32'(halted),  32'd1);
    chk("halt_no_req",  32'(mem_req), 32'd0);
    chk("halt_sb_done", 32'(exp_q.size()), 32'd0);

    // illegal instruction
    do_start();
    run_instr(16'h0150, 0, 8'h00, stop);
    if (TRAP) begin
      tick();
      chk("trap_err_sticky", 32'(err), 32'd1);
      do_start();
      chk("trap_err_clear", 32'(err), 32'd0);
      run_instr(16'hF000, 0, 8'h00, stop);
    end else begin
      run_instr(16'hF000, 0, 8'h01, stop);
    end

    // reset while a fetch is pending
    do_start();
    tick();
    chk("midfetch_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_fetch", 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset("after_rst_fetch", 8'h00);

    // reset during write-back
    do_start();
    mem_ack   = 1'b1;
    mem_rdata = 16'h07E3;
    tick();
    mem_ack = 1'b0;
    exp_q.push_back(16'h07E3);
    tick();
    tick();
    chk("pre_rst_wb", 32'(rf_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_wb", 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset("after_rst_wb", 8'h00);

    // pc wrap on the RST_PC = FF instance
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("wrap_req0",  32'(w_req),  32'd1);
    chk("wrap_addr0", 32'(w_addr), 32'h0FF);
    w_ack   = 1'b1;
    w_rdata = 16'h01A2;
    tick();
    w_ack = 1'b0;
    chk("wrap_ir", 32'(w_ir), 32'h01A2);
    repeat (3) tick();
    chk("wrap_req1",  32'(w_req),  32'd1);
    chk("wrap_addr1", 32'(w_addr), 32'h000);

    // randomized program
    do_start();
    pc = 8'h00;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (k == 59 || r >= 9)
        word = {4'hF, 12'($urandom)};
      else if (r < 7)
        word = {4'h0, 4'($urandom), LEGAL_F[$urandom_range(0, 6)], 4'($urandom)};
      else if (r == 7)
        word = {4'h0, 4'($urandom), ILL_F[$urandom_range(0, 8)], 4'($urandom)};
      else
        word = {4'($urandom_range(1, 14)), 12'($urandom)};
      run_instr(word, $urandom_range(0, 3), pc, stop);
      pc = pc + 8'd1;
      if (stop && k < 59) begin
        do_start();
        pc = 8'h00;
      end
    end
    tick();
    chk("rand_halted", 32'(halted), 32'd1);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
